// File: rtl/seq_decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a dwell-timed scan sequencer.
// Latency 1 cycle in->out; no backpressure, outputs update every cycle.
module seq_decoder_scan #(
  parameter int IN_W    = 2,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 start,
  input  logic                 loop,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic [IN_W-1:0]      in,
  output logic [(2**IN_W)-1:0] out,
  output logic [IN_W-1:0]      idx,
  output logic                 valid,
  output logic                 busy,
  output logic                 wrap,
  output logic                 done
);

  localparam int OUT_W = 2**IN_W;
  localparam logic [IN_W-1:0] LAST = {IN_W{1'b1}};

  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

  state_t             state, state_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [DWELL_W-1:0] dwell_l, dwell_d;
  logic               loop_l, loop_d;
  logic [OUT_W-1:0]   out_d;
  logic [IN_W-1:0]    idx_d;
  logic               valid_d, busy_d, wrap_d, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dwell_l <= '0;
      loop_l  <= 1'b0;
      out     <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      dwell_l <= dwell_d;
      loop_l  <= loop_d;
      out     <= out_d;
      idx     <= idx_d;
      valid   <= valid_d;
      busy    <= busy_d;
      wrap    <= wrap_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dwell_d = dwell_l;
    loop_d  = loop_l;
    idx_d   = idx;
    valid_d = valid;
    busy_d  = busy;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    case (state)
      IDLE: begin
        if (enable && !mode) begin
          state_d = DECODE;
          idx_d   = in;
          valid_d = 1'b1;
        end else if (enable && mode && start) begin
          state_d = SCAN;
          idx_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = dwell;
          dwell_d = dwell;
          loop_d  = loop;
        end
      end

      DECODE: begin
        if (enable && !mode) begin
          idx_d = in;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end

      SCAN: begin
        // Abort clears everything silently: no done/wrap on an aborted scan.
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else if (idx != LAST) begin
          idx_d = idx + 1'b1;
          cnt_d = dwell_l;
        end else if (loop_l) begin
          idx_d  = '0;
          cnt_d  = dwell_l;
          wrap_d = 1'b1;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    // Deriving out from the next idx/valid keeps the one-hot invariant by construction.
    out_d = valid_d ? (OUT_W'(1) << idx_d) : '0;
  end

endmodule
